// File: rtl/rr_arbiter.sv
// Round-robin arbiter for eight requesters with a bounded grant duration.
// Drives a registered one-hot grant plus its encoded index for a 3-to-8 decoded select.
module rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] gnt_id,
  output logic       busy
);

  localparam logic [3:0] HoldMax = 4'(MAX_HOLD);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic [7:0] grant_q, grant_d;

  logic [2:0] win;
  logic [2:0] idx;
  logic       found;
  logic       release_grant;

  // Scan upward from ptr, wrapping 7->0; first set bit wins.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign release_grant = !req[gnt_id_q] || (hold_q == HoldMax);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    grant_d  = grant_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StGrant;
          gnt_id_d = win;
          hold_d   = 4'd1;
          busy_d   = 1'b1;
          grant_d  = 8'b1 << win;
        end
      end
      StGrant: begin
        if (release_grant) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          grant_d = 8'b0;
          ptr_d   = gnt_id_q + 3'd1;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= 3'd0;
      hold_q   <= 4'd0;
      gnt_id_q <= 3'd0;
      busy_q   <= 1'b0;
      grant_q  <= 8'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
    end
  end

  assign grant  = grant_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one 3-to-8 decoded resource select among eight requesters. It tracks a rotating priority pointer and limits each grant to a bounded number of cycles. It drives a registered one-hot `grant` vector that is the decoded form of the winning 3-bit index. The block sits in front of the decoder-driven resource and is the only agent that changes its select.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one grant may last; legal range 1..15. The hold counter is 4 bits.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  8  request vector; bit i = requester i wants the resource; level-sensitive.
- `grant`  out  8  one-hot grant, equal to 3-to-8 decode of `gnt_id` while `busy`=1, else 8'b0.
- `gnt_id`  out  3  index of the current or last winner; meaningful only while `busy`=1.
- `busy`  out  1  high while a grant is active.

## Operation
- Internal state: FSM {IDLE, GRANT}, `ptr`[2:0] (highest-priority index), `hold_cnt`[3:0].
- Reset values: state=IDLE, `ptr`=0, `hold_cnt`=0, `gnt_id`=0, `busy`=0, `grant`=8'b0.
- IDLE:
  - If `req`==0, stay in IDLE; all outputs hold.
  - Otherwise scan `req` starting at `ptr`, ascending, wrapping 7->0. The first set bit wins.
  - Next state GRANT; `gnt_id`<=winner, `hold_cnt`<=1, `busy`<=1, `grant`<=decode(winner).
- GRANT, release condition: `req[gnt_id]`==0 OR `hold_cnt`==`MAX_HOLD`.
  - If released: next state IDLE, `busy`<=0, `grant`<=0, `ptr`<=`gnt_id`+1 mod 8 (7 wraps to 0). `gnt_id` retains its value.
  - Else: `hold_cnt`<=`hold_cnt`+1; `gnt_id` and `grant` unchanged.
- `req` changes on bits other than `gnt_id` during GRANT are ignored; there is no preemption.
- `grant` and `busy` are registered outputs with no combinational path from `req`.
- Exactly zero or one `grant` bit is high in every cycle.
- Reset mid-grant: outputs clear immediately, asynchronously, with no wait for `clk`. Arbitration restarts with `ptr`=0.

## Timing
- Grant latency is 1 cycle. If `req` is sampled nonzero at edge N in IDLE, `grant` is valid after edge N.
- Grant duration with the request held: exactly `MAX_HOLD` cycles. Example: `MAX_HOLD`=4 gives `hold_cnt` values 1, 2, 3, 4, then release at the next edge.
- Early release: if `req[gnt_id]` is sampled low at edge M, `grant` drops after edge M. The cycle before edge M still shows `grant` high.
- Every release is followed by at least one IDLE cycle with `grant`=0. The back-to-back period per requester is therefore `MAX_HOLD`+1 cycles.
- With `MAX_HOLD`=1, each grant lasts 1 cycle followed by 1 idle cycle.
- A requester that releases and keeps requesting alone is re-granted after the 1-cycle gap; the scan wraps back to it.
- The worst-case wait for a continuously requesting input is 7×(`MAX_HOLD`+1) cycles.

## Test plan
- **Reset:** assert `rst` with random `req` -> `grant`=0, `busy`=0, `gnt_id`=0 immediately and for as long as `rst` stays high. After release, with `req`=8'h01, `grant`=8'h01 one edge later.
- **Single holder:** `MAX_HOLD`=4, `req`=8'h08 held -> `grant`=8'h08 for 4 cycles, then 0 for 1 cycle, then 8'h08 again. `ptr` went to 4; the scan 4..7, 0..3 finds 3.
- **Full load:** `req`=8'hFF held from reset -> grant order 0,1,2,3,4,5,6,7,0. Each grant lasts 4 cycles with a 1-cycle gap; `ptr` wraps 7->0.
- **Early release and rotation:**
  - `req`=8'h24, bits 5 and 2, with `ptr`=3 -> bit 5 is granted.
  - Drop `req[5]` after 2 grant cycles -> `grant`=0 next cycle and `ptr`=6.
  - Then bit 2 is granted, since the scan goes 6, 7, 0, 1, 2.
- **Reset mid-grant:**
  - During a grant to bit 6, pulse `rst` between clock edges -> `grant` clears before the next edge.
  - After reset, `req`=8'hC0 grants bit 6 first, because `ptr`=0.
- **`MAX_HOLD`=1:** `req`=8'h81 -> grants alternate 0, gap, 7, gap, 0 …, each grant exactly 1 cycle. Check `gnt_id` matches the `grant` decode throughout.
